// File: rtl/traffic_light_monitor_pkg.sv
// traffic_light_monitor_pkg: lamp state encoding, fault codes and lamp decode shared by the monitor
package traffic_light_monitor_pkg;
    localparam logic [1:0] ST_RED    = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;
    localparam logic [1:0] ST_BAD    = 2'd3;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_ONEHOT       = 3'd1;
    localparam logic [2:0] FC_CONFLICT     = 3'd2;
    localparam logic [2:0] FC_SEQ          = 3'd3;
    localparam logic [2:0] FC_SHORT_GREEN  = 3'd4;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd5;
    localparam logic [2:0] FC_STALL        = 3'd6;

    function automatic logic [1:0] decode_lamps(input logic r, input logic y, input logic g);
        return ({r, y, g} == 3'b100) ? ST_RED :
               ({r, y, g} == 3'b010) ? ST_YELLOW :
               ({r, y, g} == 3'b001) ? ST_GREEN : ST_BAD;
    endfunction
endpackage

// File: rtl/traffic_light_monitor_lamp_dir_tracker.sv
// lamp_dir_tracker: decodes one direction's lamps, tracks its phase run length and flags
// illegal or too-short transitions against the previous sampled state.
module lamp_dir_tracker
    import traffic_light_monitor_pkg::*;
#(
    parameter int MIN_GREEN  = 5,
    parameter int MIN_YELLOW = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r,
    input  logic             y,
    input  logic             g,
    input  logic             primed,
    output logic [1:0]       state,
    output logic [1:0]       prev_state,
    output logic [CNT_W-1:0] run,
    output logic             unq,
    output logic             bad,
    output logic             illegal,
    output logic             short_green,
    output logic             short_yellow,
    output logic             yellow_to_red
);
    logic [1:0]       prev_q, prev_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             unq_q, unq_d, changed, legal;

    always_comb begin
        state         = decode_lamps(r, y, g);
        changed       = primed && (state != prev_q);
        legal         = (prev_q == ST_RED    && state == ST_GREEN)  ||
                        (prev_q == ST_GREEN  && state == ST_YELLOW) ||
                        (prev_q == ST_YELLOW && state == ST_RED);
        bad           = state == ST_BAD;
        illegal       = changed && !legal;
        yellow_to_red = changed && prev_q == ST_YELLOW && state == ST_RED;
        // the first phase after reset has an unknown true length, so it is never duration-checked
        short_green   = changed && !unq_q && prev_q == ST_GREEN && state == ST_YELLOW &&
                        run_q < CNT_W'(MIN_GREEN);
        short_yellow  = yellow_to_red && !unq_q && run_q < CNT_W'(MIN_YELLOW);
        prev_d        = state;
        run_d         = (!primed || changed) ? CNT_W'(1) : (&run_q ? run_q : run_q + 1'b1);
        unq_d         = !primed ? 1'b1 : (changed ? 1'b0 : unq_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= ST_RED;
            run_q  <= '0;
            unq_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            run_q  <= run_d;
            unq_q  <= unq_d;
        end
    end

    assign prev_state = prev_q;
    assign run        = run_q;
    assign unq        = unq_q;
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive lamp-side safety checker; latches the first fault code
// and counts completed NS green->yellow->red cycles.
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int MIN_GREEN  = 5,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_HOLD   = 200,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ns_red,
    input  logic             ns_yellow,
    input  logic             ns_green,
    input  logic             ew_red,
    input  logic             ew_yellow,
    input  logic             ew_green,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] ns_cycles
);
    logic [1:0]       ns_st, ew_st;
    logic             ns_bad, ns_ill, ns_sg, ns_sy, ns_y2r;
    logic             ew_bad, ew_ill, ew_sg, ew_sy, ew_y2r;
    logic             primed_q, fault_q, fault_d, pat_chg, stall, conflict, latch;
    logic [2:0]       code_q, code_d, code_new;
    logic [5:0]       pat_q, pat_d;
    logic [CNT_W-1:0] hold_q, hold_d, cyc_q, cyc_d;

    lamp_dir_tracker #(.MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_ns (
        .clk(clk), .rst(rst), .r(ns_red), .y(ns_yellow), .g(ns_green), .primed(primed_q),
        .state(ns_st), .prev_state(), .run(), .unq(), .bad(ns_bad), .illegal(ns_ill),
        .short_green(ns_sg), .short_yellow(ns_sy), .yellow_to_red(ns_y2r)
    );

    lamp_dir_tracker #(.MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_ew (
        .clk(clk), .rst(rst), .r(ew_red), .y(ew_yellow), .g(ew_green), .primed(primed_q),
        .state(ew_st), .prev_state(), .run(), .unq(), .bad(ew_bad), .illegal(ew_ill),
        .short_green(ew_sg), .short_yellow(ew_sy), .yellow_to_red(ew_y2r)
    );

    always_comb begin
        pat_d    = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
        pat_chg  = !primed_q || (pat_d != pat_q);
        hold_d   = pat_chg ? CNT_W'(1) : (&hold_q ? hold_q : hold_q + 1'b1);
        stall    = !pat_chg && (hold_d == CNT_W'(MAX_HOLD));
        conflict = (ns_st != ST_RED) && (ew_st != ST_RED);
        code_new = (ns_bad || ew_bad) ? FC_ONEHOT :
                   conflict           ? FC_CONFLICT :
                   (ns_ill || ew_ill) ? FC_SEQ :
                   (ns_sg || ew_sg)   ? FC_SHORT_GREEN :
                   (ns_sy || ew_sy)   ? FC_SHORT_YELLOW :
                   stall              ? FC_STALL : FC_NONE;
        // a fresh fault beats clr, so clearing never hides a violation seen in the same cycle
        latch    = (code_new != FC_NONE) && (!fault_q || clr);
        fault_d  = latch ? 1'b1 : (clr ? 1'b0 : fault_q);
        code_d   = latch ? code_new : (clr ? FC_NONE : code_q);
        cyc_d    = cyc_q + CNT_W'(ns_y2r);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            primed_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
            pat_q    <= '0;
            hold_q   <= '0;
            cyc_q    <= '0;
        end else begin
            primed_q <= 1'b1;
            fault_q  <= fault_d;
            code_q   <= code_d;
            pat_q    <= pat_d;
            hold_q   <= hold_d;
            cyc_q    <= cyc_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign ns_cycles  = cyc_q;
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive safety monitor at the lamp side of the traffic light controller: it consumes the six lamp outputs on the same clock and checks each lamp pattern and phase sequence against the legal rules. On the first violation it latches a fault and a fault code, and it counts completed NS light cycles. It sits beside the controller in the top-level wiring. It drives nothing back into the controller; `fault` is available to board logic for a fail-safe flash.

## Interface
- MIN_GREEN, 5: minimum cycles a green must be held before going to yellow
- MIN_YELLOW, 2: minimum cycles a yellow must be held before going to red
- MAX_HOLD, 200: maximum cycles the 6-lamp pattern may stay unchanged
- CNT_W, 8: width of the run, hold and cycle counters
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- clr  in  1  synchronous fault clear, active-high
- ns_red, ns_yellow, ns_green  in  1 each  NS lamps, registered controller outputs on clk
- ew_red, ew_yellow, ew_green  in  1 each  EW lamps, registered controller outputs on clk
- fault  out  1  sticky fault flag; reset 0
- fault_code  out  3  code of the first fault; 0 = none; reset 0
- ns_cycles  out  CNT_W  count of completed NS green→yellow→red cycles; wraps modulo 2^CNT_W; reset 0

## Operation
- **Per-direction decode.** Each direction decodes its lamps to RED, GREEN, YELLOW or BAD. BAD means no lamp lit or more than one lamp lit.
- **Legal transitions.** RED→GREEN, GREEN→YELLOW and YELLOW→RED are legal, as is holding any state. Every other change is illegal.
- **Run counter.** Each direction has a run counter. It loads 1 when the decoded state changes, otherwise increments, and saturates at 2^CNT_W−1.
- **Hold counter.** One counter tracks the 6-bit lamp pattern. It loads 1 on any pattern change, otherwise increments.
- **Fault codes.**
  - 1: ONEHOT. Either direction decodes BAD.
  - 2: CONFLICT. Neither direction is RED.
  - 3: SEQ. Either direction makes an illegal transition.
  - 4: SHORT_GREEN. On GREEN→YELLOW, the previous green run is less than MIN_GREEN.
  - 5: SHORT_YELLOW. On YELLOW→RED, the previous yellow run is less than MIN_YELLOW.
  - 6: STALL. The hold counter reaches MAX_HOLD while the pattern is unchanged.
- **Fault latching.**
  - When fault = 0 and any condition is true, set fault = 1 and fault_code = the lowest true code.
  - Later faults do not overwrite the latched code.
- **Clear.**
  - clr = 1 with no condition true in the same cycle: fault and fault_code go to 0.
  - clr = 1 with a condition true in the same cycle: the new fault latches, so the new fault wins over clr.
- **Cycle count.** ns_cycles increments on every NS YELLOW→RED, including one flagged SHORT_YELLOW.
- **First sample after reset.**
  - A `primed` flag is 0 out of reset.
  - On the first sample, SEQ, SHORT_GREEN and SHORT_YELLOW are suppressed, and prev-state and counters load from that sample.
  - ONEHOT and CONFLICT are checked from the first sample.
  - The first phase of each direction after reset is not duration-checked: its run counter is marked unqualified until that direction's first state change.
- **Checks while faulted.** Checking and counting continue while fault = 1.

## Timing
- **Detection latency.** Detection is combinational on the current inputs versus registered prev-state. fault and fault_code rise on the rising edge that samples the offending pattern, so they are visible the following cycle.
- **Input sampling.** No input synchronizer; the inputs are same-clock registered signals.
- **STALL.** Raised on the edge where the hold counter would reach MAX_HOLD. That is the MAX_HOLD-th consecutive edge sampling an unchanged pattern.
- **Reset.**
  - rst low at any time, including mid-phase or mid-fault: all outputs, counters and `primed` clear immediately.
  - After rst goes high, the first rising edge is the first sample.
- **Simultaneous events.** A transition that is both illegal and short reports SEQ (3) by priority.

## Structure
- **Shared package.** Holds the fault code constants (FC_NONE = 0 … FC_STALL = 6) and the lamp state encoding (RED, GREEN, YELLOW, BAD as 2-bit localparams).
- **Sub-module `lamp_dir_tracker`.** Instantiated twice, once for NS and once for EW. Per instance:
  - inputs: r, y, g, primed
  - outputs: decoded state, prev state, run count, unqualified bit
  - flags: bad, illegal, short_green, short_yellow, yellow_to_red
- **Top level.** Holds the hold counter, conflict check, priority encode, fault latch and ns_cycles.

## Test plan
- **Normal sequence.** Stimulus: NS G5/Y2/R7 with EW complementary, 3 full cycles. Required: fault = 0 throughout; ns_cycles = 3.
- **Conflict.** Stimulus: after priming, drive ns_green = 1 and ew_green = 1 for one cycle. Required: fault = 1 and fault_code = 2 on the next cycle; both stay latched after the pattern is restored.
- **Illegal and short transitions.**
  - Stimulus: NS GREEN→RED directly. Required: code 3.
  - Stimulus: after clr, NS yellow held 1 cycle then red. Required: code 5, and ns_cycles increments.
- **Onehot and simultaneous faults.** Stimulus: NS with no lamp lit while EW green (conflict also true). Required: fault_code = 1 (lowest code wins).
- **Stall.** Stimulus: hold one legal pattern for 200 cycles. Required: fault_code = 6 exactly on the 200th edge, not earlier.
- **Clear and reset.**
  - Stimulus: clr in the same cycle as a new conflict. Required: fault stays 1 with code 2.
  - Stimulus: rst low mid-phase. Required: all outputs are 0 immediately; the first post-reset green of 1 cycle does not flag SHORT_GREEN.
